// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_pkg
// Purpose  : Shared RAM command encodings and access-FSM state encoding.
//            Imported by the memory access unit and the CPU controller so
//            that both sides agree on the bus command values.
// Revision : 1.0  initial release
// ============================================================================
package mem_access_unit_pkg;

   // RAM command encodings driven on mem_cmd
   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   // Access sequencer states
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ADDR = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR      = 3'd3,
      S_DONE    = 3'd4
   } state_t;

endpackage : mem_access_unit_pkg
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : RAM-side bus between the memory access unit and the RAM.
// Ports    : mem_addr  - RAM address            (master -> slave)
//            mem_cmd   - MNONE / MREAD / MWRITE (master -> slave)
//            mem_wdata - store data             (master -> slave)
//            mem_rdata - read data, one cycle after a read address
//                                               (slave -> master)
// Revision : 1.0  initial release
// ============================================================================
interface mem_access_unit_if #(
   parameter int AW = 9,
   parameter int DW = 16
);
   logic [AW-1:0] mem_addr;
   logic [1:0]    mem_cmd;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_cmd,
      output mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_cmd,
      input  mem_wdata,
      output mem_rdata
   );
endinterface : mem_access_unit_if
`default_nettype wire

// File: rtl/mem_access_unit_pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_reg
// Purpose  : AW-bit program counter with synchronous reset, load and
//            increment. Load has priority over increment; increment wraps
//            modulo 2^AW.
// Ports    : clk, reset - clock and synchronous active-high reset
//            load_i     - load pc_i
//            inc_i      - add one (ignored when load_i is set)
//            pc_i       - load value
//            pc_o       - current PC
// Revision : 1.0  initial release
// ============================================================================
module pc_reg #(
   parameter int AW = 9
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic          load_i,
   input  wire logic          inc_i,
   input  wire logic [AW-1:0] pc_i,
   output logic      [AW-1:0] pc_o
);
   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = pc_i;
      end else if (inc_i) begin
         pc_d = pc_q + 1'b1;   // natural AW-bit overflow gives the wrap
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;
endmodule : pc_reg
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Sequences single RAM reads and writes for a small CPU and holds
//            the program counter. A request is accepted only in IDLE; the
//            address and store data are latched at acceptance so later input
//            changes cannot disturb the access in flight.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            data_addr_in   - data address source
//            pc_in, load_pc, inc_pc - PC load value and controls
//            req, req_write, addr_sel, write_data - access request
//            mem            - RAM bus (master side)
//            read_data      - last captured read word
//            pc_out         - current PC
//            busy, done     - not-IDLE flag, completion pulse
// Revision : 1.0  initial release
// ============================================================================
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int AW = 9,
   parameter int DW = 16
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic [AW-1:0] data_addr_in,
   input  wire logic [AW-1:0] pc_in,
   input  wire logic          load_pc,
   input  wire logic          inc_pc,
   input  wire logic          req,
   input  wire logic          req_write,
   input  wire logic          addr_sel,
   input  wire logic [DW-1:0] write_data,
   mem_access_unit_if.master  mem,
   output logic      [DW-1:0] read_data,
   output logic      [AW-1:0] pc_out,
   output logic               busy,
   output logic               done
);
   state_t        state_q;
   state_t        state_d;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic          accept_w;
   logic [1:0]    cmd_w;

   // ---------------------------------------------------------------------
   // Program counter: updates every cycle regardless of the sequencer
   // ---------------------------------------------------------------------
   pc_reg #(
      .AW (AW)
   ) u_pc_reg (
      .clk    (clk),
      .reset  (reset),
      .load_i (load_pc),
      .inc_i  (inc_pc),
      .pc_i   (pc_in),
      .pc_o   (pc_out)
   );

   // ---------------------------------------------------------------------
   // Sequencer: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Sequencer: next state and command
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cmd_w    = MNONE;
      accept_w = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               accept_w = 1'b1;
               state_d  = req_write ? S_WR : S_RD_ADDR;
            end
         end
         S_RD_ADDR: begin
            cmd_w   = MREAD;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            // Address stays up so the RAM output is stable for the capture
            cmd_w   = MREAD;
            state_d = S_DONE;
         end
         S_WR: begin
            cmd_w   = MWRITE;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: request latch and read capture
   // pc_out is the registered PC, so a same-cycle PC update is not seen
   // by the latch.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept_w) begin
            addr_q  <= addr_sel ? pc_out : data_addr_in;
            wdata_q <= write_data;
         end
         if (state_q == S_RD_WAIT) begin
            rdata_q <= mem.mem_rdata;
         end
      end
   end

   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_cmd   = cmd_w;
   assign read_data     = rdata_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
endmodule : mem_access_unit
`default_nettype wire
